// File: rtl/vga_plot_arbiter_if.sv
// Requester side of the shared vga_adapter plot port.
// Each requester owns one slice of the packed x/y/colour buses.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 5
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [8*NUM_REQ-1:0]  req_x;
  logic [7*NUM_REQ-1:0]  req_y;
  logic [12*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_last,
    output req_x,
    output req_y,
    output req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_x,
    input  req_y,
    input  req_colour,
    output req_ready
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter in front of the vga_adapter plot port.
// A grant is held for a whole sprite burst; pixels leave with 1-cycle latency.
module vga_plot_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int MAX_BURST   = 512,
  parameter int STALL_LIMIT = 15,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120
) (
  input  logic               clk,
  input  logic               reset,
  vga_plot_arbiter_if.slave  req,
  output logic [NUM_REQ-1:0] grant,
  output logic [7:0]         x_out,
  output logic [6:0]         y_out,
  output logic [11:0]        colour_out,
  output logic               plot,
  output logic               burst_done,
  output logic               truncated
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [PW-1:0] PIX_TOP   = PW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_TOP = SW'(STALL_LIMIT - 1);
  localparam logic [8:0]    XLIM      = 9'(X_MAX);
  localparam logic [7:0]    YLIM      = 8'(Y_MAX);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [PW-1:0] pix_cnt;
  logic [SW-1:0] stall_cnt;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  int            j;

  logic          accept;
  logic          on_screen;
  logic [7:0]    cur_x;
  logic [6:0]    cur_y;
  logic [11:0]   cur_colour;
  logic          cur_last;
  logic [IW-1:0] ptr_next;

  // Ready is only the registered grant, so it never depends on valid.
  assign req.req_ready = grant;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!sel_found && req.req_valid[j]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    cur_x      = req.req_x[int'(gidx)*8 +: 8];
    cur_y      = req.req_y[int'(gidx)*7 +: 7];
    cur_colour = req.req_colour[int'(gidx)*12 +: 12];
    cur_last   = req.req_last[gidx];
    accept     = (state == BURST) && req.req_valid[gidx];
    on_screen  = ({1'b0, cur_x} < XLIM) && ({1'b0, cur_y} < YLIM);
    ptr_next   = (gidx == LAST_IDX) ? '0 : gidx + IW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      pix_cnt    <= '0;
      stall_cnt  <= '0;
      grant      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      burst_done <= 1'b0;
      truncated  <= 1'b0;
    end else begin
      plot       <= 1'b0;
      burst_done <= 1'b0;
      truncated  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            state     <= BURST;
            gidx      <= sel_idx;
            grant     <= NUM_REQ'(1) << sel_idx;
            pix_cnt   <= '0;
            stall_cnt <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            stall_cnt <= '0;
            pix_cnt   <= pix_cnt + PW'(1);
            if (on_screen) begin
              x_out      <= cur_x;
              y_out      <= cur_y;
              colour_out <= cur_colour;
              plot       <= 1'b1;
            end
            // A last pixel wins over the burst cap: clean release.
            if (cur_last || pix_cnt == PIX_TOP) begin
              state      <= IDLE;
              grant      <= '0;
              ptr        <= ptr_next;
              burst_done <= 1'b1;
              truncated  <= !cur_last;
            end
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
            if (stall_cnt == STALL_TOP) begin
              state      <= IDLE;
              grant      <= '0;
              ptr        <= ptr_next;
              burst_done <= 1'b1;
              truncated  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
